bcd_display_driver: RTL and testbench

- Sequential, parametrised binary-to-seven-segment driver for the board HEX displays.
- Accepts a two's-complement or unsigned binary value through a start/done handshake.
- Converts it iteratively with shift-add-3, one bit per clock.
- Drives registered, active-low segment patterns for NUM_DIGITS decimal digits plus a sign digit, and flags values that do not fit.

---
 rtl/bcd_display_driver_if.sv | 24 ++
 rtl/bcd_display_driver.sv | 160 ++++++++++++++++
 tb/tb_bcd_display_driver.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_driver_if.sv
// Handshake and display bundle for bcd_display_driver.
// The master drives start/value_in; the slave returns status and segments.
interface bcd_display_driver_if #(
    parameter int IN_WIDTH   = 10,
    parameter int NUM_DIGITS = 3
);
    logic                    start;
    logic [IN_WIDTH-1:0]     value_in;
    logic                    ready;
    logic                    done;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic [6:0]              sign_seg;
    logic                    overflow;

    modport master (
        output start, value_in,
        input  ready, done, seg_out, sign_seg, overflow
    );

    modport slave (
        input  start, value_in,
        output ready, done, seg_out, sign_seg, overflow
    );
endinterface

// File: rtl/bcd_display_driver.sv
// Iterative binary to seven-segment driver (shift-add-3, one bit per clock).
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the leading digit.
module bcd_display_driver #(
    parameter int IN_WIDTH    = 10,
    parameter int NUM_DIGITS  = 3,
    parameter int SIGNED_MODE = 1
) (
    input  logic clock,
    input  logic resetn,
    bcd_display_driver_if.slave bus
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = BW + IN_WIDTH;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

    state_t                  state, state_next;
    logic [SW-1:0]           sr;
    logic [SW-1:0]           adj;
    logic [CW-1:0]           cnt;
    logic                    sign;
    logic                    ovf_pending;
    logic                    neg;
    logic [IN_WIDTH-1:0]     mag;
    logic [7*NUM_DIGITS-1:0] disp;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [6:0]              sign_q;
    logic                    ovf_q;
    logic                    done_q;

    assign bus.ready    = (state == IDLE);
    assign bus.done     = done_q;
    assign bus.seg_out  = seg_q;
    assign bus.sign_seg = sign_q;
    assign bus.overflow = ovf_q;

    // Magnitude and sign of the incoming value (negation of the most
    // negative value wraps to 2^(IN_WIDTH-1), still valid as unsigned).
    always_comb begin
        neg = 1'b0;
        mag = bus.value_in;
        if (SIGNED_MODE != 0 && bus.value_in[IN_WIDTH-1]) begin
            neg = 1'b1;
            mag = -bus.value_in;
        end
    end

    // Add 3 to every BCD nibble >= 5, all judged on pre-add values.
    always_comb begin
        adj = sr;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sr[IN_WIDTH+4*k +: 4] >= 4'd5)
                adj[IN_WIDTH+4*k +: 4] = sr[IN_WIDTH+4*k +: 4] + 4'd3;
        end
    end

    // Segment image of the finished BCD digits.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
`endif
        disp = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            disp[7*k +: 7] = seg7(sr[IN_WIDTH+4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && sr[IN_WIDTH+4*k +: 4] == 4'd0)
                disp[7*k +: 7] = BLANK;
            else
                lead = 1'b0;
        end
`endif
        if (ovf_pending)
            disp = {NUM_DIGITS{DASH}};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = CONVERT;
            CONVERT: if (cnt == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load, shift-add-3 iterations, and output registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sr          <= '0;
            cnt         <= '0;
            sign        <= 1'b0;
            ovf_pending <= 1'b0;
            seg_q       <= '1;
            sign_q      <= BLANK;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr          <= {{BW{1'b0}}, mag};
                        cnt         <= '0;
                        sign        <= neg;
                        ovf_pending <= ({{(64-IN_WIDTH){1'b0}}, mag} >= LIMIT);
                    end
                end
                CONVERT: begin
                    sr  <= {adj[SW-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    seg_q  <= disp;
                    sign_q <= sign ? DASH : BLANK;
                    ovf_q  <= ovf_pending;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomized self-checking bench for bcd_display_driver.
// Runs a signed and an unsigned instance against a decimal reference model.
module tb_bcd_display_driver;
    localparam int W = 10;
    localparam int N = 3;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic         clock = 1'b0;
    logic         resetn;
    logic         start_drv;
    logic [W-1:0] value_drv;
    logic         sel;
    int           checks = 0;
    int           errors = 0;
    logic [6:0]   seg_tab [10];

    always #5 clock = ~clock;

    bcd_display_driver_if #(.IN_WIDTH(W), .NUM_DIGITS(N)) ifs ();
    bcd_display_driver_if #(.IN_WIDTH(W), .NUM_DIGITS(N)) ifu ();

    bcd_display_driver #(.IN_WIDTH(W), .NUM_DIGITS(N), .SIGNED_MODE(1)) dut (
        .clock(clock), .resetn(resetn), .bus(ifs.slave)
    );
    bcd_display_driver #(.IN_WIDTH(W), .NUM_DIGITS(N), .SIGNED_MODE(0)) dut_u (
        .clock(clock), .resetn(resetn), .bus(ifu.slave)
    );

    assign ifs.start    = start_drv & ~sel;
    assign ifu.start    = start_drv & sel;
    assign ifs.value_in = value_drv;
    assign ifu.value_in = value_drv;

    logic         ready_o, done_o, ov_o;
    logic [7*N-1:0] seg_o;
    logic [6:0]   sign_o;
    assign ready_o = sel ? ifu.ready    : ifs.ready;
    assign done_o  = sel ? ifu.done     : ifs.done;
    assign ov_o    = sel ? ifu.overflow : ifs.overflow;
    assign seg_o   = sel ? ifu.seg_out  : ifs.seg_out;
    assign sign_o  = sel ? ifu.sign_seg : ifs.sign_seg;

    // Decimal reference: magnitude split with / and %, leading zeros by size.
    function automatic void model(input logic [W-1:0] v, input logic sgn,
                                  output logic [7*N-1:0] seg,
                                  output logic [6:0] ss, output logic ov);
        int  mag;
        int  p;
        logic neg;
        neg = sgn && v[W-1];
        mag = neg ? (1 << W) - int'(v) : int'(v);
        ov  = (mag >= 1000);
        ss  = neg ? DASH : BLANK;
        seg = '0;
        p   = 1;
        for (int k = 0; k < N; k++) begin
            if (ov) seg[7*k +: 7] = DASH;
            else    seg[7*k +: 7] = seg_tab[(mag / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (!ov && k > 0 && mag < p) seg[7*k +: 7] = BLANK;
`endif
            p = p * 10;
        end
    endfunction

    task automatic test_reset();
        sel = 1'b0; start_drv = 1'b0; value_drv = '0; resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (ifs.seg_out !== 21'h1FFFFF || ifu.seg_out !== 21'h1FFFFF) begin
            errors++; $display("FAIL reset_seg got %h/%h want 1fffff", ifs.seg_out, ifu.seg_out);
        end
        checks++;
        if (ifs.sign_seg !== BLANK || ifu.sign_seg !== BLANK) begin
            errors++; $display("FAIL reset_sign got %b/%b want %b", ifs.sign_seg, ifu.sign_seg, BLANK);
        end
        checks++;
        if (ifs.done !== 1'b0 || ifs.overflow !== 1'b0 || ifu.done !== 1'b0 || ifu.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags done %b/%b ovf %b/%b want 0", ifs.done, ifu.done, ifs.overflow, ifu.overflow);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (ifs.ready !== 1'b1 || ifu.ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b/%b want 1", ifs.ready, ifu.ready);
        end
    endtask

    task automatic test_convert(input logic s, input int nrand);
        logic [W-1:0]   dir [6];
        logic [W-1:0]   v;
        logic [7*N-1:0] eseg;
        logic [6:0]     esign;
        logic           eov;
        int             lat;
        sel = s;
        if (!s) dir = '{10'h3F6, 10'h200, 10'h1FF, 10'h000, 10'h3FF, 10'h001};
        else    dir = '{10'h3E7, 10'h3E8, 10'h3FF, 10'h000, 10'h009, 10'h064};
        for (int i = 0; i < 6 + nrand; i++) begin
            v = (i < 6) ? dir[i] : W'($urandom);
            model(v, !s, eseg, esign, eov);
            @(negedge clock);
            for (int t = 0; t < 20 && !ready_o; t++) @(negedge clock);
            checks++;
            if (ready_o !== 1'b1) begin
                errors++; $display("FAIL conv_ready_idle got %b want 1", ready_o);
            end
            start_drv = 1'b1; value_drv = v;
            @(posedge clock);
            #1;
            start_drv = 1'b0; value_drv = W'($urandom);
            lat = 0;
            for (int n = 1; n <= W + 4; n++) begin
                @(posedge clock);
                #1;
                value_drv = W'($urandom);
                if (n == 1) begin
                    checks++;
                    if (ready_o !== 1'b0) begin
                        errors++; $display("FAIL conv_busy got ready=%b want 0", ready_o);
                    end
                end
                if (done_o === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            checks++;
            if (lat != W + 1) begin
                errors++; $display("FAIL conv_latency v=%h got %0d want %0d", v, lat, W + 1);
            end
            checks++;
            if (seg_o !== eseg) begin
                errors++; $display("FAIL conv_seg v=%h got %b want %b", v, seg_o, eseg);
            end
            checks++;
            if (sign_o !== esign || ov_o !== eov) begin
                errors++; $display("FAIL conv_sign_ovf v=%h got %b/%b want %b/%b", v, sign_o, ov_o, esign, eov);
            end
            checks++;
            if (ready_o !== 1'b1) begin
                errors++; $display("FAIL conv_ready_done got %b want 1", ready_o);
            end
            @(posedge clock);
            #1;
            checks++;
            if (done_o !== 1'b0 || seg_o !== eseg) begin
                errors++; $display("FAIL conv_hold v=%h got done=%b seg=%b want 0/%b", v, done_o, seg_o, eseg);
            end
        end
    endtask

    task automatic test_handshake();
        logic [W-1:0]   q [$];
        int             acc [$];
        int             dones;
        logic           rp;
        logic [7*N-1:0] eseg;
        logic [6:0]     esign;
        logic           eov;
        logic [W-1:0]   v;
        sel = 1'b0; dones = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clock);
            value_drv = W'($urandom);
            start_drv = (cyc < 30);
            rp = ready_o;
            @(posedge clock);
            if (rp && start_drv) begin
                q.push_back(value_drv);
                acc.push_back(cyc);
            end
            #1;
            if (done_o === 1'b1) begin
                dones++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL hs_spurious_done cyc=%0d", cyc);
                end else begin
                    v = q.pop_front();
                    model(v, 1'b1, eseg, esign, eov);
                    if (seg_o !== eseg || sign_o !== esign || ov_o !== eov) begin
                        errors++; $display("FAIL hs_result v=%h got %b/%b/%b want %b/%b/%b", v, seg_o, sign_o, ov_o, eseg, esign, eov);
                    end
                end
            end
        end
        start_drv = 1'b0;
        checks++;
        if (acc.size() != 3 || acc[0] != 0 || acc[1] != 12 || acc[2] != 24) begin
            errors++; $display("FAIL hs_accepts got %0d accepts first=%0d want 3 at 0,12,24", acc.size(), (acc.size() > 0) ? acc[0] : -1);
        end
        checks++;
        if (dones != 3) begin
            errors++; $display("FAIL hs_done_count got %0d want 3", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        sel = 1'b0; dones = 0;
        @(negedge clock);
        for (int t = 0; t < 20 && !ready_o; t++) @(negedge clock);
        start_drv = 1'b1; value_drv = W'($urandom);
        @(posedge clock);
        #1;
        start_drv = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (seg_o !== 21'h1FFFFF || sign_o !== BLANK || ov_o !== 1'b0) begin
            errors++; $display("FAIL mid_blank got %h/%b/%b want 1fffff/%b/0", seg_o, sign_o, ov_o, BLANK);
        end
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_status got done=%b ready=%b want 0/1", done_o, ready_o);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clock);
            #1;
            if (done_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL mid_no_done got %0d pulses want 0", dones);
        end
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        test_reset();
        test_convert(1'b0, 20);
        test_convert(1'b1, 20);
        test_handshake();
        test_reset_mid();
        test_convert(1'b0, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
